// File: rtl/ad5543_pkg.sv
// Shared types and helpers for the AD5543 serial transmitter.
//   tx_state_t   : frame sequencer states
//   frame_len()  : aclk cycles cs_n is held low for one frame
//   UNDERRUN_MAX : saturation value of the underrun counter
package ad5543_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } tx_state_t;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  function automatic int unsigned frame_len(input int unsigned dw, input int unsigned sclk_div,
                                            input int unsigned cs_gap);
    return sclk_div * (2 * dw + 1) + cs_gap;
  endfunction

endpackage

// File: rtl/ad5543_serial_tx_if.sv
// AXI-Stream sample channel into the AD5543 transmitter.
//   tdata  : signed sample, DW bits
//   tvalid : sample available (master drives)
//   tready : accept strobe (slave drives)
interface ad5543_serial_tx_if #(
  parameter int unsigned DW = 16
) ();

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/ad5543_tick_gen.sv
// Enable-gated down-counter producing a one-cycle tick every DIV cycles.
//   aclk   : clock
//   areset : synchronous active-high reset
//   en     : count enable; while low the counter sits at DIV-1
//   tick   : high during the cycle the count is zero (and en is high)
module ad5543_tick_gen #(
  parameter int unsigned DIV = 80
) (
  input  logic aclk,
  input  logic areset,
  input  logic en,
  output logic tick
);

  localparam int unsigned   CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge aclk) begin
    if (areset || !en || (cnt_q == '0)) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/ad5543_serial_tx.sv
// Streaming transmitter for the AD5543 16-bit serial DAC. Pulls one sample per
// sample period from an AXI-Stream slave and shifts it out MSB first as one
// cs_n frame; the DAC latches on the cs_n rise.
//   aclk, areset  : clock, synchronous active-high reset
//   en            : enables the sample-period ticker
//   s_axis        : sample stream (slave modport)
//   sclk/sdi/cs_n : DAC pins, all registered
//   busy          : frame in progress
//   underrun      : one-cycle pulse when a tick finds no sample
//   underrun_cnt  : saturating underrun count
// Build option: define AD5543_OFFSET_BINARY_EN to invert the sample MSB
// (two's complement -> offset binary for the unipolar DAC).
module ad5543_serial_tx
  import ad5543_pkg::*;
#(
  parameter int unsigned DW         = 16,
  parameter int unsigned SCLK_DIV   = 2,
  parameter int unsigned SAMPLE_DIV = 80,
  parameter int unsigned CS_GAP     = 2
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                en,
  ad5543_serial_tx_if.slave   s_axis,
  output logic                sclk,
  output logic                sdi,
  output logic                cs_n,
  output logic                busy,
  output logic                underrun,
  output logic [15:0]         underrun_cnt
);

  localparam int unsigned FRAME_LEN = frame_len(DW, SCLK_DIV, CS_GAP);
  localparam int unsigned HALF_W    = $clog2(2 * DW);
  localparam int unsigned GAP_W     = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DW - 1);

  if (SAMPLE_DIV < FRAME_LEN + 2) begin : g_div_check
    $error("SAMPLE_DIV must be at least FRAME_LEN+2");
  end

  tx_state_t         state_q;
  logic [DW-1:0]     shreg_q;
  logic [HALF_W-1:0] half_q;
  logic [GAP_W-1:0]  gap_q;
  logic              sclk_q, cs_n_q, busy_q, underrun_q;
  logic [15:0]       underrun_cnt_q;
  logic              sample_tick, phase_tick;
  logic [DW-1:0]     word;

  ad5543_tick_gen #(
    .DIV (SAMPLE_DIV)
  ) u_sample_tick (
    .aclk   (aclk),
    .areset (areset),
    .en     (en),
    .tick   (sample_tick)
  );

  // SCLK half-period counter; held at reload while idle so SETUP always
  // starts with a full half-period.
  ad5543_tick_gen #(
    .DIV (SCLK_DIV)
  ) u_phase_tick (
    .aclk   (aclk),
    .areset (areset),
    .en     (state_q != IDLE),
    .tick   (phase_tick)
  );

`ifdef AD5543_OFFSET_BINARY_EN
  assign word = {~s_axis.tdata[DW-1], s_axis.tdata[DW-2:0]};
`else
  assign word = s_axis.tdata;
`endif

  assign s_axis.tready = (state_q == IDLE) && sample_tick;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      half_q         <= '0;
      gap_q          <= '0;
      sclk_q         <= 1'b0;
      cs_n_q         <= 1'b1;
      busy_q         <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      underrun_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sample_tick) begin
            if (s_axis.tvalid) begin
              shreg_q <= word;
              sclk_q  <= 1'b0;
              cs_n_q  <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= SETUP;
            end else begin
              underrun_q <= 1'b1;
              if (underrun_cnt_q != UNDERRUN_MAX) begin
                underrun_cnt_q <= underrun_cnt_q + 16'd1;
              end
            end
          end
        end
        SETUP: begin
          if (phase_tick) begin
            half_q  <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (phase_tick) begin
            half_q <= half_q + HALF_W'(1);
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // Falling edge: the only point where sdi may advance.
              sclk_q <= 1'b0;
              if (half_q == LAST_HALF) begin
                gap_q   <= GAP_W'(CS_GAP - 1);
                state_q <= HOLD;
              end else begin
                shreg_q <= shreg_q << 1;
              end
            end
          end
        end
        HOLD: begin
          if (gap_q == '0) begin
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sclk         = sclk_q;
  assign sdi          = shreg_q[DW-1];
  assign cs_n         = cs_n_q;
  assign busy         = busy_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_ad5543_serial_tx.sv
module tb_ad5543_serial_tx;

  localparam int unsigned DW         = 16;
  localparam int unsigned SCLK_DIV   = 2;
  localparam int unsigned SAMPLE_DIV = 80;
  localparam int unsigned CS_GAP     = 2;
  localparam int unsigned FRAME_LEN  = 68;

  logic        aclk   = 1'b0;
  logic        areset = 1'b1;
  logic        en     = 1'b0;
  logic        sclk, sdi, cs_n, busy, underrun;
  logic [15:0] underrun_cnt;

  ad5543_serial_tx_if #(.DW(DW)) s_axis ();

  ad5543_serial_tx #(
    .DW         (DW),
    .SCLK_DIV   (SCLK_DIV),
    .SAMPLE_DIV (SAMPLE_DIV),
    .CS_GAP     (CS_GAP)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .en           (en),
    .s_axis       (s_axis),
    .sclk         (sclk),
    .sdi          (sdi),
    .cs_n         (cs_n),
    .busy         (busy),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word the DAC should see for a given sample.
  function automatic logic [15:0] dac_word(input logic [15:0] d);
`ifdef AD5543_OFFSET_BINARY_EN
    return 16'((int'(d) + 32768) % 65536);
`else
    return d;
`endif
  endfunction

  // Reference model state: edges since the ticker was (re)started, cycles of
  // frame left, pending underrun pulse, expected count, expected words.
  int          k = 0;
  int          frame_rem = 0;
  bit          und_pend = 0;
  int          und_cnt_m = 0;
  bit          aborted = 0;
  bit          chk_en = 0;
  logic [15:0] exp_q[$];

  // Collector state.
  logic        prev_sclk = 1'b0, prev_sdi = 1'b0, prev_cs_n = 1'b1;
  int          nbits = 0, low_cycles = 0, recv_count = 0, und_pulses = 0;
  logic [15:0] shin = '0;

  always @(negedge aclk) begin
    bit exp_tick, exp_idle;
    exp_tick = en && ((k % SAMPLE_DIV) == SAMPLE_DIV - 1);
    exp_idle = (frame_rem == 0);
    if (chk_en) begin
      check("tready", s_axis.tready, exp_tick && exp_idle);
      check("busy", busy, frame_rem > 0);
      check("cs_n", cs_n, frame_rem == 0);
      check("underrun", underrun, und_pend);
      check("underrun_cnt", underrun_cnt, und_cnt_m);
      if (underrun) und_pulses++;
      if (cs_n) check("sclk_idle", sclk, 1'b0);
      if (prev_sclk && sclk) check("sdi_stable", sdi, prev_sdi);
      if (prev_cs_n && !cs_n) begin
        nbits = 0;
        low_cycles = 0;
      end
      if (!cs_n) low_cycles++;
      if (!prev_sclk && sclk && !cs_n) begin
        shin = {shin[14:0], sdi};
        nbits++;
      end
      if (!prev_cs_n && cs_n) begin
        if (aborted) begin
          aborted = 0;
          check("abort_no_word", nbits < DW, 1'b1);
        end else begin
          check("frame_len", low_cycles, FRAME_LEN);
          check("sclk_rises", nbits, DW);
          if (exp_q.size() == 0) begin
            check("recv_unexpected", shin, 32'hFFFF_FFFF);
          end else begin
            check("recv_data", shin, exp_q.pop_front());
          end
          recv_count++;
        end
      end
    end
    prev_sclk = sclk;
    prev_sdi  = sdi;
    prev_cs_n = cs_n;

    // Advance the model to the next rising edge.
    if (areset) begin
      k = 0;
      if (frame_rem > 0) begin
        void'(exp_q.pop_back());
        aborted = 1;
      end
      frame_rem = 0;
      und_pend  = 0;
      und_cnt_m = 0;
    end else begin
      k = en ? k + 1 : 0;
      und_pend = exp_tick && exp_idle && !s_axis.tvalid;
      if (und_pend && und_cnt_m < 65535) und_cnt_m++;
      if (frame_rem > 0) frame_rem--;
      if (exp_tick && exp_idle && s_axis.tvalid) begin
        frame_rem = FRAME_LEN;
        exp_q.push_back(dac_word(s_axis.tdata));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Present a sample until it is accepted; reports cycles waited.
  task automatic send(input logic [15:0] d, output int waited);
    bit done;
    done = 0;
    waited = 0;
    s_axis.tdata  = d;
    s_axis.tvalid = 1'b1;
    for (int i = 0; i < 3 * SAMPLE_DIV && !done; i++) begin
      @(negedge aclk);
      if (s_axis.tready) done = 1;
      waited = i + 1;
      @(posedge aclk);
      #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = 16'($urandom);
  endtask

  task automatic reset_dut();
    areset = 1'b1;
    wait_cycles(2);
    areset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   waited, base, u0;
    real  v;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    wait_cycles(3);
    areset = 1'b0;
    chk_en = 1;
    @(negedge aclk);
    check("rst_sdi", sdi, 1'b0);
    check("rst_sclk", sclk, 1'b0);
    check("rst_cs_n", cs_n, 1'b1);
    @(posedge aclk);
    #1;

    // Single word, first accept 80 cycles after en.
    en = 1'b1;
    send(16'h8001, waited);
    check("t1_latency", waited, SAMPLE_DIV);
    wait_cycles(72);
    check("t1_recv", recv_count, 1);

    // Continuous random stream.
    send(16'($urandom), waited);
    for (int i = 0; i < 5; i++) begin
      send(16'($urandom), waited);
      check("t2_period", waited, SAMPLE_DIV);
    end
    wait_cycles(72);
    check("t2_recv", recv_count, 7);

    // Underrun: three ticks with nothing valid.
    reset_dut();
    und_pulses = 0;
    base = recv_count;
    wait_cycles(245);
    check("t3_underrun_cnt", underrun_cnt, 16'd3);
    check("t3_pulses", und_pulses, 3);
    check("t3_recv", recv_count, base);

    // 200-point sine stream.
    reset_dut();
    base = recv_count;
    for (int i = 0; i < 200; i++) begin
      v = 32767.0 * $sin(2.0 * 3.14159265358979 * i / 200.0);
      send(16'($rtoi(v)), waited);
    end
    wait_cycles(72);
    check("t4_recv", recv_count, base + 200);
    check("t4_underrun_cnt", underrun_cnt, 16'd0);
    check("t4_queue_empty", exp_q.size(), 0);

    // Reset during bit 5 of a frame.
    base = recv_count;
    send(16'hA5C3, waited);
    wait_cycles(23);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("t5_cs_n", cs_n, 1'b1);
    check("t5_sclk", sclk, 1'b0);
    check("t5_busy", busy, 1'b0);
    @(posedge aclk);
    #1;
    send(16'h3C5A, waited);
    wait_cycles(72);
    check("t5_recv", recv_count, base + 1);

    // en dropped mid-frame.
    base = recv_count;
    send(16'($urandom), waited);
    wait_cycles(10);
    en = 1'b0;
    u0 = und_cnt_m;
    wait_cycles(200);
    check("t6_recv", recv_count, base + 1);
    check("t6_no_underrun", underrun_cnt, u0);
    en = 1'b1;
    send(16'($urandom), waited);
    check("t6_latency", waited, SAMPLE_DIV);
    wait_cycles(72);
    check("t6_recv2", recv_count, base + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
